fpu_sgnj_stage: RTL and testbench
=================================

Name: fpu_sgnj_stage

Overview:
- Registered execute stage for the FPU sign-injection group (fsgnj.s, fsgnjn.s, fsgnjx.s, and the pseudo-ops fmv.s/fabs.s/fneg.s).
- Sits between the FP register-file read/dispatch stage and FP writeback.
- Contains the combinational sign-injection datapath, then a 2-entry in-order output buffer with valid/ready handshakes on both sides.
- Bit-exact: no NaN canonicalisation and no exception flags, per the sign-injection semantics.

Parameters:
- W, 32: FP operand width (binary32); the sign bit is bit W-1.
- TAGW, 5: width of the destination-register tag carried alongside the result.
- DEPTH, 2: output buffer entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all buffered entries (branch mispredict / trap).
- in_valid  in  1  dispatch presents an operation.
- in_ready  out  1  stage can accept this cycle.
- in_op  in  2  00=SGNJ, 01=SGNJN, 10=SGNJX, 11=reserved.
- in_x1  in  W  rs1 value: magnitude source.
- in_x2  in  W  rs2 value: sign source.
- in_tag  in  TAGW  rd index.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  writeback consumes the head entry.
- out_y  out  W  result.
- out_tag  out  TAGW  rd index of the result.
- out_illegal  out  1  head entry was issued with reserved op 11.

Behaviour:
- Result function, bits [W-2:0] of y always equal in_x1[W-2:0]. Sign bit by op:
  - SGNJ: y[W-1] = x2[W-1].
  - SGNJN: y[W-1] = ~x2[W-1].
  - SGNJX: y[W-1] = x1[W-1] ^ x2[W-1].
  - Reserved (11): y = x1 unchanged and illegal = 1.
- NaN, infinity, zero and subnormal inputs follow the same rule; the payload passes through untouched.
- Accept: the transfer happens on the edge where in_valid & in_ready & ~flush. The computed {y, tag, illegal} is written into the buffer tail.
- Latency: an accepted op appears at out_valid on the cycle after acceptance; it can be consumed the same cycle out_valid rises.
- Buffer state is count ∈ {0, 1, 2}, with state names EMPTY, ONE and FULL.
  - in_ready = (count != 2), a function of registered state only.
  - out_valid = (count != 0).
  - Pop happens when out_valid & out_ready.
- Transitions (push = accept, pop = consume):
  - EMPTY: push -> ONE; no push -> EMPTY.
  - ONE: push & pop -> ONE (head replaced by new entry); push only -> FULL; pop only -> EMPTY; neither -> ONE.
  - FULL: pop -> ONE (in_ready = 0, so no push); no pop -> FULL.
- Ordering is strictly FIFO. Head outputs are held stable while out_valid & ~out_ready.
- Implement as two registered slots with a head pointer, or as a head/skid pair. In either case, outputs come directly from registers.
- Flush:
  - On any edge with flush = 1, count -> 0.
  - An in_valid on that cycle is dropped.
  - A pop on that cycle is still considered consumed; writeback must ignore it itself.
  - Flush has lower priority than rst.
- Reset: on any edge with rst = 1, count -> 0. This gives out_valid = 0 and in_ready = 1 from the next cycle.
  - out_y, out_tag and out_illegal reset to 0.
  - Reset mid-operation discards all buffered entries.
- Payload registers need not be cleared on flush, but out_y/out_tag/out_illegal must never change while out_valid & ~out_ready.

Decomposition:
- Shared FPU package holds:
  - the op enum (SGNJ=2'b00, SGNJN=2'b01, SGNJX=2'b10, RSVD=2'b11);
  - localparams for binary32 field positions (sign 31, exponent 30:23, mantissa 22:0);
  - a packed result struct {y, tag, illegal}.
- One natural sub-module: the existing combinational sign-injection unit, instantiated once for the SGNJX/SGNJ/SGNJN datapath, with op muxing around its sign input.
- The buffer stays inline.

Test Plan:
- Basic ops: x1=0x3F800000, x2=0xC0000000, out_ready=1.
  - SGNJ -> y=0xBF800000.
  - SGNJN -> y=0x3F800000.
  - SGNJX -> y=0xBF800000.
  - Each appears 1 cycle after accept, with tag echoed and illegal=0.
- Special values:
  - x1=0x7FC00001, x2=0x80000000, SGNJ -> y=0xFFC00001 (payload kept).
  - x1=0x80000000, x2=0x80000000, SGNJX -> y=0x00000000.
  - op=11, x1=0x12345678 -> y=0x12345678, illegal=1.
- Backpressure: out_ready=0, push tags 1,2,3 on consecutive cycles.
  - in_ready drops after the 2nd accept; tag 3 is held by the source.
  - Raise out_ready: outputs in order are tag 1, then 2, then 3; out_y is stable while stalled.
- Full throughput: out_ready=1, in_valid every cycle for 16 ops.
  - One result per cycle; count stays at 1; in_ready stays 1.
- Flush: with 2 entries buffered, assert flush together with in_valid (tag 7).
  - Next cycle out_valid=0 and in_ready=1; tag 7 never appears.
- Reset mid-op: with FULL and out_ready=0, assert rst for 1 cycle.
  - Next cycle out_valid=0, in_ready=1, out_y=0, out_tag=0.
  - The next accept completes normally.

Source files
------------

// File: rtl/fpu_sgnj_pkg.sv
// fpu_sgnj_pkg: shared FPU types and binary32 field positions for the sign-injection stage
package fpu_sgnj_pkg;
  localparam int SIGN_BIT = 31;
  localparam int EXP_HI = 30;
  localparam int EXP_LO = 23;
  localparam int MAN_HI = 22;
  localparam int MAN_LO = 0;
  localparam int FP_W = SIGN_BIT + 1;
  localparam int TAG_W = 5;
  typedef enum logic [1:0] {SGNJ = 2'b00, SGNJN = 2'b01, SGNJX = 2'b10, RSVD = 2'b11} sgnj_op_e;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} buf_state_e;
  typedef struct packed {
    logic [FP_W-1:0]  y;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } sgnj_res_t;
endpackage

// File: rtl/fpu_sgnj_unit.sv
// fpu_sgnj_unit: combinational sign injection, magnitude from x1, sign optionally xored with x1's sign
module fpu_sgnj_unit #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_x1,
  input  logic         i_sgn,
  input  logic         i_xor,
  output logic [W-1:0] o_y
);
  assign o_y = {i_sgn ^ (i_xor & i_x1[W-1]), i_x1[W-2:0]};
endmodule

// File: rtl/fpu_sgnj_stage.sv
// fpu_sgnj_stage: registered sign-injection execute stage with a 2-entry head/skid output buffer
module fpu_sgnj_stage
  import fpu_sgnj_pkg::*;
#(
  parameter int W     = FP_W,
  parameter int TAGW  = TAG_W,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [W-1:0]    in_x1,
  input  logic [W-1:0]    in_x2,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_y,
  output logic [TAGW-1:0] out_tag,
  output logic            out_illegal
);
  localparam buf_state_e LAST = buf_state_e'(DEPTH[1:0]);
  buf_state_e r_state, w_next;
  sgnj_res_t  r_head, r_skid, w_new;
  sgnj_op_e   w_op;
  logic       w_sgn, w_xor, w_push, w_pop, w_unused;
  logic [W-1:0] w_y;
  assign w_op = sgnj_op_e'(in_op);
  assign w_sgn = (w_op == SGNJN) ? ~in_x2[W-1] : (w_op == RSVD) ? in_x1[W-1] : in_x2[W-1];
  assign w_xor = (w_op == SGNJX);
  assign w_unused = ^in_x2[W-2:0];
  fpu_sgnj_unit #(.W(W)) u_unit (
    .i_x1  (in_x1),
    .i_sgn (w_sgn),
    .i_xor (w_xor),
    .o_y   (w_y)
  );
  assign w_new = '{y: w_y, tag: in_tag, illegal: (w_op == RSVD)};
  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop = out_valid & out_ready;
  always_ff @(posedge clk) begin
    if (rst || flush) r_state <= EMPTY;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == EMPTY) ? (w_push ? ONE : EMPTY) :
             (r_state == ONE)   ? ((w_push && !w_pop) ? FULL : (!w_push && w_pop) ? EMPTY : ONE) :
                                  (w_pop ? ONE : FULL);
  end
  always_comb begin
    in_ready = (r_state != LAST);
    out_valid = (r_state != EMPTY);
  end
  // Head only changes when empty or consumed, so a stalled head stays stable.
  always_ff @(posedge clk) begin
    if (rst) r_head <= '0;
    else if (w_push && (r_state == EMPTY || w_pop)) r_head <= w_new;
    else if (w_pop && r_state == FULL) r_head <= r_skid;
  end
  always_ff @(posedge clk) begin
    if (w_push && r_state == ONE && !w_pop) r_skid <= w_new;
  end
  assign out_y = r_head.y;
  assign out_tag = r_head.tag;
  assign out_illegal = r_head.illegal;
endmodule

// File: tb/tb_fpu_sgnj_stage.sv
// tb_fpu_sgnj_stage: scoreboard bench with directed and random traffic against a reference model
module tb_fpu_sgnj_stage;
  logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid, out_illegal;
  logic [1:0]  in_op = 0;
  logic [31:0] in_x1 = 0, in_x2 = 0, out_y;
  logic [4:0]  in_tag = 0, out_tag;
  int n_checks = 0, n_fail = 0;
  logic [37:0] q[$];
  logic        held = 0;
  logic [37:0] held_v;

  fpu_sgnj_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] model(input logic [1:0] op, input logic [31:0] x1, input logic [31:0] x2, input logic [4:0] tag);
    logic s;
    case (op)
      2'b00: s = x2[31];
      2'b01: s = !x2[31];
      2'b10: s = x1[31] != x2[31];
      default: s = x1[31];
    endcase
    return {s, x1[30:0], tag, op == 2'b11};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      held = 0;
    end else begin
      if (held) check("stall_stable", {out_valid, out_y, out_tag, out_illegal}, {1'b1, held_v});
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_out", {out_y, out_tag, out_illegal}, 38'h0 ^ {out_y, out_tag, ~out_illegal});
        else check("sb_result", {out_y, out_tag, out_illegal}, q.pop_front());
      end
      held = out_valid && !out_ready && !flush;
      held_v = {out_y, out_tag, out_illegal};
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(model(in_op, in_x1, in_x2, in_tag));
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] x1, input logic [31:0] x2, input logic [4:0] tag);
    in_valid = 1; in_op = op; in_x1 = x1; in_x2 = x2; in_tag = tag;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic issue_chk(input logic [1:0] op, input logic [31:0] x1, input logic [31:0] x2, input logic [4:0] tag, input logic [31:0] ey, input logic eill);
    issue(op, x1, x2, tag);
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    check("lat_y", out_y, ey);
    check("lat_tag", out_tag, tag);
    check("lat_illegal", out_illegal, eill);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_y", out_y, 0);
    check("rst_tag", out_tag, 0);
    check("rst_illegal", out_illegal, 0);
    @(posedge clk); #1;
    out_ready = 1;
    issue_chk(2'b00, 32'h3F800000, 32'hC0000000, 5'd1, 32'hBF800000, 0);
    issue_chk(2'b01, 32'h3F800000, 32'hC0000000, 5'd2, 32'h3F800000, 0);
    issue_chk(2'b10, 32'h3F800000, 32'hC0000000, 5'd3, 32'hBF800000, 0);
    issue_chk(2'b00, 32'h7FC00001, 32'h80000000, 5'd4, 32'hFFC00001, 0);
    issue_chk(2'b10, 32'h80000000, 32'h80000000, 5'd5, 32'h00000000, 0);
    issue_chk(2'b11, 32'h12345678, 32'h80000000, 5'd6, 32'h12345678, 1);
    // backpressure: third op must wait for space
    out_ready = 0;
    issue(2'b00, 32'h40400000, 32'h80000000, 5'd1);
    issue(2'b01, 32'h40800000, 32'h00000000, 5'd2);
    in_valid = 1; in_op = 2'b10; in_x1 = 32'hC0A00000; in_x2 = 32'h80000000; in_tag = 5'd3;
    repeat (3) begin
      @(negedge clk);
      check("bp_ready", in_ready, 0);
      check("bp_head", out_tag, 1);
      @(posedge clk); #1;
    end
    out_ready = 1;
    issue(2'b10, 32'hC0A00000, 32'h80000000, 5'd3);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_op = 2'($urandom_range(0, 2)); in_x1 = $urandom; in_x2 = $urandom; in_tag = 5'(i);
      @(negedge clk);
      check("tp_ready", in_ready, 1);
      if (i > 0) check("tp_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 0;
    issue(2'b00, 32'h11111111, 32'h80000000, 5'd4);
    issue(2'b01, 32'h22222222, 32'h80000000, 5'd5);
    in_valid = 1; in_op = 2'b00; in_x1 = 32'h33333333; in_x2 = 0; in_tag = 5'd7; flush = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    @(negedge clk);
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 0;
    issue(2'b01, 32'h44444444, 32'h80000000, 5'd8);
    issue(2'b10, 32'hC5555555, 32'h00000000, 5'd9);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_y", out_y, 0);
    check("mid_rst_tag", out_tag, 0);
    @(posedge clk); #1;
    out_ready = 1;
    issue_chk(2'b10, 32'hC1200000, 32'h80000000, 5'd10, 32'h41200000, 0);
    for (int i = 0; i < 300; i++) begin
      in_valid = $urandom_range(0, 1) == 1;
      in_op = 2'($urandom_range(0, 3));
      in_x1 = ($urandom_range(0, 7) == 0) ? 32'h7FC00001 : $urandom;
      in_x2 = $urandom;
      in_tag = 5'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 15) == 0;
      @(posedge clk); #1;
    end
    in_valid = 0; flush = 0; out_ready = 1;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
